cascade_time_counter: RTL
=========================

Name: cascade_time_counter

Overview:
Parametrised chain of modulo counters, e.g. seconds/minutes/hours, advanced by a single-cycle tick strobe from the clock divider. Each stage wraps at its own modulus and passes a carry (up) or borrow (down) to the next stage in the same cycle. The block adds direction control, parallel load, enable/hold, clean one-cycle carry pulses and a whole-chain rollover flag. It replaces per-unit counters in the clock datapath; outputs feed the BCD/display logic.

Parameters:
N_STAGES, 3, number of cascaded stages; stage 0 is least significant.
CW, 7, bit width of every stage count field.
MODULI, '{60,60,24}, per-stage modulus, index 0 first; each must be in 2..2**CW. Elaboration error otherwise.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-low reset
tick_i  in  1  advance strobe, one clk cycle wide, e.g. 1 Hz
en_i  in  1  count enable; when low, ticks are ignored and counts hold
down_i  in  1  0 = count up, 1 = count down
load_i  in  1  parallel load strobe
load_val_i  in  N_STAGES*CW  load values; stage i at bits [i*CW +: CW]
count_o  out  N_STAGES*CW  current counts, same packing
carry_o  out  N_STAGES  registered one-cycle pulse per stage that wrapped
rollover_o  out  1  registered one-cycle pulse when the top stage wrapped

Behaviour:
- Reset is sampled on the clk edge with reset=0. All counts become 0; carry_o and rollover_o become 0. Reset overrides every other input. Reset in mid-chain clears all stages in the same cycle.
- Advance condition: adv = tick_i & en_i & ~load_i & reset.
- Terminal value of stage i: up = MODULI[i]-1, down = 0. term[i] is combinational from the stage's current count and down_i.
- Stage i steps when adv & term[0..i-1] all true (stage 0 steps on adv alone). The ripple is combinational, so the whole chain updates on one edge.
- Up step: count+1, or 0 when at the terminal value. Down step: count-1, or MODULI[i]-1 when at 0.
- Latency: tick_i high at edge t, so count_o shows the new value after edge t. No multi-cycle ripple.
- carry_o[i] is registered high for exactly the cycle after stage i wrapped, i.e. it stepped from its terminal value. It is 0 otherwise, including after reset and after a load.
- rollover_o equals carry_o[N_STAGES-1].
- Load: when load_i=1 (and reset=1), every stage takes its load_val_i field on that edge. Any field >= MODULI[i] is stored as MODULI[i]-1. Load beats a simultaneous tick: the tick is dropped and no carry is produced.
- en_i=0: counts and direction are irrelevant and held; carry_o is 0 next cycle.
- down_i may change between ticks. The value sampled at the tick edge is used for the whole chain in that cycle.
- tick_i held high for several cycles advances once per cycle. The block does no edge detection; the divider guarantees single-cycle strobes.
- No state machine beyond the counters. All outputs are driven directly from registers.

Decomposition:
- Package clock_pkg holds:
  - CW_DEF = 7 and N_STAGES_DEF = 3.
  - MODULI_DEF = '{60,60,24}.
  - typedef count_t = logic [CW_DEF-1:0].
  - A function clamp_load(val, mod).
- Sub-module mod_stage: one modulo up/down counter. Parameters MOD and CW. Ports: clk, reset, step_i, down_i, load_i, load_val_i, count_o, term_o, wrap_o.
- The top module generates N_STAGES instances of mod_stage, builds the ripple-AND chain and registers carry_o/rollover_o.

Test Plan:
- Reset and count up: assert reset=0 for 2 cycles, then apply 60 ticks with en=1, down=0. Expect count_o stage0 to go 0→59→0 and stage1 = 1. carry_o[0] pulses once, the cycle after the 59→0 edge. rollover_o stays 0.
- Full rollover: load {23,59,59} (hours, min, sec), then apply one tick up. Expect all stages 0, carry_o = 3'b111 for one cycle, and rollover_o = 1 for one cycle.
- Count down with borrow: load {0,0,0} and set down=1, then apply one tick. Expect {23,59,59}, carry_o = 3'b111, rollover_o = 1.
- Load beats tick and load clamp: apply load_i and tick_i together with load_val sec=75, min=10, hr=5. Expect sec=59, min=10, hr=5; counts unchanged on the next cycle without a tick; carry_o = 0.
- Enable hold: set en=0 and apply 10 ticks. Expect counts unchanged and carry_o = 0. Then set en=1 and apply one tick from sec=59. Expect sec=0 and min+1.
- Reset mid-run: from {12,34,56}, drive reset=0 on the same edge as a tick. Expect all counts 0 and carry_o/rollover_o = 0. Counting resumes from 0 on the first tick after reset=1.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared defaults and helpers for the cascaded time counter.
package clock_pkg;

    localparam int unsigned CW_DEF       = 7;
    localparam int unsigned N_STAGES_DEF = 3;

    // Seconds, minutes, hours; index 0 is the least significant stage.
    localparam int unsigned MODULI_DEF [N_STAGES_DEF] = '{60, 60, 24};

    typedef logic [CW_DEF-1:0] count_t;

    // Saturate an out-of-range load value to the stage's largest legal count.
    function automatic int unsigned clamp_load(input int unsigned val, input int unsigned mod);
        if (val >= mod) begin
            return mod - 1;
        end
        return val;
    endfunction

endpackage

// File: rtl/mod_stage.sv
// One modulo-MOD up/down counter stage with parallel load and wrap detect.
module mod_stage #(
    parameter int unsigned MOD = 60,
    parameter int unsigned CW  = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step_i,
    input  logic          down_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic [CW-1:0] count_o,
    output logic          term_o,
    output logic          wrap_o
);
    import clock_pkg::*;

    localparam logic [CW-1:0] MAX = CW'(MOD - 1);

    // A modulus outside 2..2**CW cannot be represented by this stage.
    generate
        if (MOD < 2 || MOD > (1 << CW)) begin : g_bad_mod
            $error("mod_stage: MOD must lie in 2..2**CW");
        end
    endgenerate

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] load_clamped;

    assign load_clamped = CW'(clamp_load(32'(load_val_i), MOD));

    // Terminal value depends on direction: the top of the range going up, zero going down.
    assign term_o = down_i ? (count_q == '0) : (count_q == MAX);

    // A wrap is a step taken from the terminal value; the top module registers it.
    assign wrap_o = step_i & term_o;

    assign count_o = count_q;

    // Next count: load has priority over a step; steps wrap at the range ends.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_clamped;
        end else if (step_i) begin
            if (down_i) begin
                count_d = term_o ? MAX : count_q - 1'b1;
            end else begin
                count_d = term_o ? '0 : count_q + 1'b1;
            end
        end
    end

    // Count register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cascade_time_counter.sv
// Chain of modulo counters (e.g. sec/min/hr) advanced by a single-cycle tick.
// The carry/borrow ripple is combinational so the whole chain updates on one edge.
module cascade_time_counter
    import clock_pkg::*;
#(
    parameter int unsigned N_STAGES         = N_STAGES_DEF,
    parameter int unsigned CW               = CW_DEF,
    parameter int unsigned MODULI [N_STAGES] = MODULI_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick_i,
    input  logic                   en_i,
    input  logic                   down_i,
    input  logic                   load_i,
    input  logic [N_STAGES*CW-1:0] load_val_i,
    output logic [N_STAGES*CW-1:0] count_o,
    output logic [N_STAGES-1:0]    carry_o,
    output logic                   rollover_o
);

    logic                adv;
    logic [N_STAGES-1:0] step;
    logic [N_STAGES-1:0] term;
    logic [N_STAGES-1:0] wrap;

    // The top stage has no successor, so its terminal flag feeds nothing.
    logic unused_top_term;
    assign unused_top_term = term[N_STAGES-1];

    // Load and reset both suppress counting on the same edge.
    assign adv = tick_i & en_i & ~load_i & reset;

    assign step[0] = adv;

    genvar i;
    generate
        for (i = 1; i < N_STAGES; i++) begin : g_ripple
            assign step[i] = step[i-1] & term[i-1];
        end

        for (i = 0; i < N_STAGES; i++) begin : g_stage
            mod_stage #(
                .MOD (MODULI[i]),
                .CW  (CW)
            ) u_stage (
                .clk        (clk),
                .reset      (reset),
                .step_i     (step[i]),
                .down_i     (down_i),
                .load_i     (load_i),
                .load_val_i (load_val_i[i*CW +: CW]),
                .count_o    (count_o[i*CW +: CW]),
                .term_o     (term[i]),
                .wrap_o     (wrap[i])
            );
        end
    endgenerate

    // Register wrap events into clean one-cycle carry and rollover pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            carry_o    <= '0;
            rollover_o <= 1'b0;
        end else begin
            carry_o    <= wrap;
            rollover_o <= wrap[N_STAGES-1];
        end
    end

endmodule
